// File: rtl/branch_compare_seq_if.sv
// Request/response bundle between ID-stage branch logic and the chunk-serial comparator.
// Latency: none (wires only).
// Backpressure: requester must hold off i_start while o_busy is high; starts seen then are dropped.
interface branch_compare_seq_if #(
    parameter int DATA_LEN = 32
);
    logic                i_start;
    logic                i_flush;
    logic [2:0]          i_mode;
    logic [DATA_LEN-1:0] i_data_A;
    logic [DATA_LEN-1:0] i_data_B;
    logic                o_busy;
    logic                o_done;
    logic                o_result;
    logic                o_is_equal;
    logic                o_is_less;

    modport master (
        output i_start, i_flush, i_mode, i_data_A, i_data_B,
        input  o_busy, o_done, o_result, o_is_equal, o_is_less
    );

    modport slave (
        input  i_start, i_flush, i_mode, i_data_A, i_data_B,
        output o_busy, o_done, o_result, o_is_equal, o_is_less
    );
endinterface

// File: rtl/branch_compare_seq.sv
// Multi-mode operand comparator, CHUNK_LEN bits per cycle MSB first, early exit on first difference.
// Latency: o_done after accept edge + k + 1 edges (k = chunks examined, 1..NUM_CHUNKS).
// Backpressure: o_busy high in CMP; i_start ignored there, accepted again in IDLE/DONE.
module branch_compare_seq #(
    parameter int DATA_LEN  = 32,
    parameter int CHUNK_LEN = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    branch_compare_seq_if.slave  bus
);
    localparam int NUM_CHUNKS = DATA_LEN / CHUNK_LEN;
    localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(NUM_CHUNKS - 1);

    generate
        if (CHUNK_LEN < 1 || (DATA_LEN % CHUNK_LEN) != 0) begin : g_bad_chunk
            $error("branch_compare_seq: DATA_LEN must be a multiple of CHUNK_LEN");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

    state_t              state;
    logic [DATA_LEN-1:0] a_q;
    logic [DATA_LEN-1:0] b_q;
    logic [2:0]          mode_q;
    logic [IDX_W-1:0]    idx;
    logic                pend_vld;
    logic                pend_diff;
    logic                pend_lt;
    logic                pend_last;

    logic [CHUNK_LEN-1:0] chunk_a;
    logic [CHUNK_LEN-1:0] chunk_b;
    logic                 signed_mode;
    logic                 chunk_lt;

    function automatic logic predicate(input logic [2:0] mode, input logic lt, input logic eq);
        case (mode)
            3'b000:         predicate = eq;
            3'b001:         predicate = !eq;
            3'b010, 3'b011: predicate = lt;
            3'b100, 3'b101: predicate = lt | eq;
            default:        predicate = !lt & !eq;
        endcase
    endfunction

    // Only the top chunk carries the sign bit; lower chunks always order unsigned.
    always_comb begin
        chunk_a     = CHUNK_LEN'(a_q >> (int'(idx) * CHUNK_LEN));
        chunk_b     = CHUNK_LEN'(b_q >> (int'(idx) * CHUNK_LEN));
        signed_mode = (mode_q == 3'b010) || (mode_q == 3'b100) || (mode_q == 3'b110);
        chunk_lt    = (idx == TOP_IDX && signed_mode) ? ($signed(chunk_a) < $signed(chunk_b))
                                                      : (chunk_a < chunk_b);
    end

    // Each chunk's verdict is registered into pend_* and acted on the following edge,
    // keeping the wide compare out of the state-decision path.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state          <= IDLE;
            a_q            <= '0;
            b_q            <= '0;
            mode_q         <= '0;
            idx            <= '0;
            pend_vld       <= 1'b0;
            pend_diff      <= 1'b0;
            pend_lt        <= 1'b0;
            pend_last      <= 1'b0;
            bus.o_busy     <= 1'b0;
            bus.o_done     <= 1'b0;
            bus.o_result   <= 1'b0;
            bus.o_is_equal <= 1'b0;
            bus.o_is_less  <= 1'b0;
        end else begin
            bus.o_done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (bus.i_start && !bus.i_flush) begin
                        state      <= CMP;
                        a_q        <= bus.i_data_A;
                        b_q        <= bus.i_data_B;
                        mode_q     <= bus.i_mode;
                        idx        <= TOP_IDX;
                        pend_vld   <= 1'b0;
                        bus.o_busy <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                CMP: begin
                    if (bus.i_flush) begin
                        state      <= IDLE;
                        bus.o_busy <= 1'b0;
                    end else if (pend_vld && (pend_diff || pend_last)) begin
                        state          <= DONE;
                        bus.o_busy     <= 1'b0;
                        bus.o_done     <= 1'b1;
                        bus.o_is_equal <= !pend_diff;
                        bus.o_is_less  <= pend_diff & pend_lt;
                        bus.o_result   <= predicate(mode_q, pend_diff & pend_lt, !pend_diff);
                    end else begin
                        pend_vld  <= 1'b1;
                        pend_diff <= (chunk_a != chunk_b);
                        pend_lt   <= chunk_lt;
                        pend_last <= (idx == '0);
                        if (idx != '0) begin
                            idx <= idx - 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_branch_compare_seq.sv
// Directed + random checks of branch_compare_seq at CHUNK_LEN 1, 8 and 32 against a full-width model.
module tb_branch_compare_seq;
    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic res;
        logic eq;
        logic lt;
        int   cyc;
    } exp_t;

    exp_t q[3][$];
    exp_t last_exp[3];

    branch_compare_seq_if #(.DATA_LEN(32)) if1 ();
    branch_compare_seq_if #(.DATA_LEN(32)) if8 ();
    branch_compare_seq_if #(.DATA_LEN(32)) if32 ();

    branch_compare_seq #(.DATA_LEN(32), .CHUNK_LEN(1))  u1  (.i_clk(clk), .i_rst_n(rst_n), .bus(if1));
    branch_compare_seq #(.DATA_LEN(32), .CHUNK_LEN(8))  u8  (.i_clk(clk), .i_rst_n(rst_n), .bus(if8));
    branch_compare_seq #(.DATA_LEN(32), .CHUNK_LEN(32)) u32 (.i_clk(clk), .i_rst_n(rst_n), .bus(if32));

    function automatic int chunk_of(input int w);
        return (w == 0) ? 1 : (w == 1) ? 8 : 32;
    endfunction

    function automatic exp_t model(input logic [2:0] m, input logic [31:0] a, input logic [31:0] b,
                                   input int cl, input int c0);
        exp_t        x;
        int          nc;
        int          k;
        bit          found;
        logic [63:0] msk;
        logic [63:0] dif;
        logic        sgn;
        nc    = 32 / cl;
        k     = nc;
        found = 0;
        msk   = (64'd1 << cl) - 64'd1;
        dif   = {32'd0, a ^ b};
        for (int i = nc - 1; i >= 0; i--) begin
            if (!found && (((dif >> (i * cl)) & msk) != 64'd0)) begin
                k     = nc - i;
                found = 1;
            end
        end
        sgn  = (m == 3'd2) || (m == 3'd4) || (m == 3'd6);
        x.eq = (a == b);
        x.lt = sgn ? ($signed(a) < $signed(b)) : (a < b);
        case (m)
            3'd0:       x.res = x.eq;
            3'd1:       x.res = !x.eq;
            3'd2, 3'd3: x.res = x.lt;
            3'd4, 3'd5: x.res = x.lt | x.eq;
            default:    x.res = !x.lt & !x.eq;
        endcase
        x.cyc = c0 + k + 2;
        return x;
    endfunction

    function automatic logic [4:0] outs(input int w);
        case (w)
            0:       return {if1.o_busy, if1.o_done, if1.o_result, if1.o_is_equal, if1.o_is_less};
            1:       return {if8.o_busy, if8.o_done, if8.o_result, if8.o_is_equal, if8.o_is_less};
            default: return {if32.o_busy, if32.o_done, if32.o_result, if32.o_is_equal, if32.o_is_less};
        endcase
    endfunction

    task automatic drive_if(input int w, input logic st, input logic fl, input logic [2:0] m,
                            input logic [31:0] a, input logic [31:0] b);
        case (w)
            0: begin if1.i_start = st; if1.i_flush = fl; if1.i_mode = m; if1.i_data_A = a; if1.i_data_B = b; end
            1: begin if8.i_start = st; if8.i_flush = fl; if8.i_mode = m; if8.i_data_A = a; if8.i_data_B = b; end
            default: begin if32.i_start = st; if32.i_flush = fl; if32.i_mode = m; if32.i_data_A = a; if32.i_data_B = b; end
        endcase
    endtask

    task automatic start_on(input int w, input logic [2:0] m, input logic [31:0] a, input logic [31:0] b);
        drive_if(w, 1'b1, 1'b0, m, a, b);
        q[w].push_back(model(m, a, b, chunk_of(w), cyc));
    endtask

    task automatic mon(input int w, input logic d, input logic r, input logic e, input logic l);
        exp_t x;
        if (d !== 1'b1) return;
        vectors++;
        assert (q[w].size() > 0) else begin
            miscompares++;
            $error("FAIL unexpected_done dut%0d: observed done at cycle %0d, expected none", w, cyc);
        end
        if (q[w].size() == 0) return;
        x = q[w].pop_front();
        last_exp[w] = x;
        vectors++;
        assert ({r, e, l} === {x.res, x.eq, x.lt}) else begin
            miscompares++;
            $error("FAIL result dut%0d: observed res/eq/lt=%b%b%b expected %b%b%b", w, r, e, l, x.res, x.eq, x.lt);
        end
        vectors++;
        assert (cyc === x.cyc) else begin
            miscompares++;
            $error("FAIL latency dut%0d: observed done cycle %0d expected %0d", w, cyc, x.cyc);
        end
    endtask

    always @(negedge clk) begin
        mon(0, if1.o_done, if1.o_result, if1.o_is_equal, if1.o_is_less);
        mon(1, if8.o_done, if8.o_result, if8.o_is_equal, if8.o_is_less);
        mon(2, if32.o_done, if32.o_result, if32.o_is_equal, if32.o_is_less);
    end

    task automatic drain(input string tag);
        int n = 0;
        while ((q[0].size() + q[1].size() + q[2].size()) != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        assert (n < 300) else begin
            miscompares++;
            $error("FAIL timeout_%s: observed %0d pending results after %0d cycles, expected 0", tag,
                   q[0].size() + q[1].size() + q[2].size(), n);
            for (int w = 0; w < 3; w++) q[w].delete();
        end
    endtask

    task automatic check_outs(input int w, input logic [4:0] exp, input string tag);
        logic [4:0] got;
        got = outs(w);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s dut%0d: observed busy/done/res/eq/lt=%b expected %b", tag, w, got, exp);
        end
    endtask

    task automatic run1(input logic [2:0] m, input logic [31:0] a, input logic [31:0] b, input string tag);
        start_on(1, m, a, b);
        @(negedge clk);
        drive_if(1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        drain(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  m;
        logic        all_idle;

        rst_n = 1'b0;
        for (int w = 0; w < 3; w++) begin
            drive_if(w, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
            last_exp[w] = '{res: 1'b0, eq: 1'b0, lt: 1'b0, cyc: 0};
        end
        repeat (3) @(negedge clk);
        for (int w = 0; w < 3; w++) check_outs(w, 5'b00000, "reset_state");
        rst_n = 1'b1;
        @(negedge clk);

        // Directed compares on the 8-bit-chunk instance
        run1(3'd0, 32'h0000000A, 32'h0000000A, "eq_equal");
        run1(3'd1, 32'h0000000A, 32'h0000000C, "ne_low_chunk");
        run1(3'd2, 32'hFFFF0000, 32'h00000000, "lt_signed");
        run1(3'd3, 32'hFFFF0000, 32'h00000000, "ltu");
        run1(3'd7, 32'hFFFF0000, 32'h00000000, "gtu");
        run1(3'd4, 32'h12345678, 32'h12345678, "le_equal");
        run1(3'd6, 32'h00000100, 32'h000000FF, "gt_mid_chunk");

        // Flush mid-compare, with a competing start that must lose
        drive_if(1, 1'b1, 1'b0, 3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF);
        @(negedge clk);
        drive_if(1, 1'b0, 1'b0, 3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF);
        @(negedge clk);
        drive_if(1, 1'b1, 1'b1, 3'd1, 32'h1, 32'h2);
        @(negedge clk);
        drive_if(1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        check_outs(1, {2'b00, last_exp[1].res, last_exp[1].eq, last_exp[1].lt}, "flush_retain");
        drive_if(1, 1'b1, 1'b1, 3'd0, 32'h5, 32'h5);
        @(negedge clk);
        drive_if(1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        check_outs(1, {2'b00, last_exp[1].res, last_exp[1].eq, last_exp[1].lt}, "flush_beats_start");
        repeat (8) @(negedge clk);
        run1(3'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, "after_flush");

        // Start during CMP is ignored; start during DONE is accepted
        start_on(1, 3'd3, 32'h00000001, 32'h00000002);
        @(negedge clk);
        drive_if(1, 1'b1, 1'b0, 3'd0, 32'h5, 32'h5);
        @(negedge clk);
        drive_if(1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        n = 0;
        while (if8.o_done !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        assert (n < 50) else begin
            miscompares++;
            $error("FAIL timeout_first_done: observed no done in %0d cycles, expected done", n);
        end
        start_on(1, 3'd6, 32'h80000000, 32'h7FFFFFFF);
        @(negedge clk);
        drive_if(1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        drain("back_to_back");

        // Reset in the middle of a compare
        start_on(1, 3'd0, 32'd0, 32'd0);
        @(negedge clk);
        drive_if(1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_outs(1, 5'b00000, "reset_mid_cmp");
        q[1].delete();
        rst_n = 1'b1;
        last_exp[1] = '{res: 1'b0, eq: 1'b0, lt: 1'b0, cyc: 0};
        @(negedge clk);
        repeat (6) @(negedge clk);
        check_outs(1, 5'b00000, "idle_after_reset");
        run1(3'd5, 32'h00000003, 32'h00000009, "leu_after_reset");

        // Random sweep across all three chunk widths
        for (int v = 0; v < 80; v++) begin
            n = 0;
            all_idle = 1'b0;
            while (!all_idle && n < 100) begin
                all_idle = !(outs(0)[4] | outs(1)[4] | outs(2)[4]);
                if (!all_idle) begin
                    @(negedge clk);
                    n++;
                end
            end
            vectors++;
            assert (all_idle) else begin
                miscompares++;
                $error("FAIL timeout_busy: observed busy after %0d cycles, expected idle", n);
            end
            m = 3'($urandom_range(0, 7));
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = a;
                1:       b = a ^ (32'd1 << $urandom_range(0, 31));
                2:       b = {a[31:16], 16'($urandom)};
                default: b = $urandom;
            endcase
            for (int w = 0; w < 3; w++) start_on(w, m, a, b);
            @(negedge clk);
            for (int w = 0; w < 3; w++) drive_if(w, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain("random");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
